// File: rtl/corner_merge_pkg.sv
// Shared definitions for corner_merge: end-of-frame marker layout and marker FSM states.
package corner_merge_pkg;

    // Marker layout, MSB first: {EOF_TAG, zero fill, frame record count}
    localparam logic [3:0] EOF_TAG = 4'hF;
    localparam int TAG_W = 4;
    localparam int CNT_W = 16;

    typedef enum logic [0:0] {
        EOF_IDLE  = 1'b0,
        EOF_ARMED = 1'b1
    } eof_state_t;

    // Bit offset of the tag field within a record of width dw
    function automatic int tag_lsb(input int dw);
        return dw - TAG_W;
    endfunction

endpackage

// File: rtl/cm_lane_fifo.sv
// Per-lane record FIFO; pointers carry one extra wrap bit to tell full from empty.
module cm_lane_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 16
) (
    input  logic          c,
    input  logic          rst,
    input  logic          wr,
    input  logic          rd,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wp;
    logic [AW:0]   rp;
    logic          do_wr;
    logic          do_rd;

    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign dout  = mem[rp[AW-1:0]];

    // A read in the same cycle frees the slot, so a full FIFO still takes the write
    assign do_rd = rd && !empty;
    assign do_wr = wr && (!full || do_rd);

    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_wr) wp <= wp + 1'b1;
            if (do_rd) rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge c) begin
        if (do_wr) mem[wp[AW-1:0]] <= din;
    end

endmodule

// File: rtl/corner_merge.sv
// Merges LANES detector streams into one registered output with round-robin arbitration,
// per-frame counters and a MAX_QV cap. Define CORNER_MERGE_EOF_EN for the end-of-frame marker.
module corner_merge
    import corner_merge_pkg::*;
#(
    parameter int          LANES  = 4,
    parameter int          DW     = 32,
    parameter int          DEPTH  = 16,
    parameter logic [15:0] MAX_QV = 16'd16383
) (
    input  logic                c,
    input  logic                rst,
    input  logic                en,
    input  logic                fv,
    input  logic [LANES*DW-1:0] d,
    input  logic [LANES-1:0]    dv,
    input  logic                rdy,
    output logic [DW-1:0]       q,
    output logic                qv,
    output logic [15:0]         qv_cnt,
    output logic [15:0]         drop_cnt
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LANES-1:0] full;
    logic [LANES-1:0] empty;
    logic [LANES-1:0] rd;
    logic [DW-1:0]    lane_dout [LANES];

    logic [LW-1:0] last_lane;
    logic [LW-1:0] grant_lane;
    logic [LW:0]   cand_sum;
    logic          grant_any;
    logic          grant;
    logic          can_load;
    logic          at_limit;
    logic          load_record;
    logic          discard;
    logic          accept;
    logic          counted_valid;
    logic          fv_d;
    logic          fv_rise;
    logic [16:0]   pending_total;
    logic [4:0]    drop_inc;
    logic [16:0]   drop_sum;
    logic [15:0]   drop_next;
    logic [15:0]   qv_next;
    logic          out_valid;
    logic [DW-1:0] out_data;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        cm_lane_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
            .c     (c),
            .rst   (rst),
            .wr    (en && dv[i]),
            .rd    (rd[i]),
            .din   (d[i*DW +: DW]),
            .dout  (lane_dout[i]),
            .full  (full[i]),
            .empty (empty[i])
        );
    end

`ifdef CORNER_MERGE_EOF_EN
    localparam int TAG_LSB = tag_lsb(DW);

    eof_state_t    eof_state;
    eof_state_t    eof_next;
    logic          emit_marker;
    logic          out_marker;
    logic [DW-1:0] marker;

    assign counted_valid = out_valid && !out_marker;

    always_ff @(posedge c or posedge rst) begin
        if (rst) eof_state <= EOF_IDLE;
        else     eof_state <= eof_next;
    end

    // Armed on fv falling; fires once everything upstream of q has drained, cancelled by a new frame
    always_comb begin
        eof_next    = eof_state;
        emit_marker = 1'b0;
        marker      = '0;
        marker[TAG_LSB +: TAG_W] = EOF_TAG;
        marker[CNT_W-1:0]        = qv_cnt;
        case (eof_state)
            EOF_IDLE: begin
                if (fv_d && !fv) eof_next = EOF_ARMED;
            end
            EOF_ARMED: begin
                if (fv) begin
                    eof_next = EOF_IDLE;
                end else if ((&empty) && !out_valid) begin
                    emit_marker = 1'b1;
                    eof_next    = EOF_IDLE;
                end
            end
            default: eof_next = EOF_IDLE;
        endcase
    end

    always_ff @(posedge c or posedge rst) begin
        if (rst)              out_marker <= 1'b0;
        else if (load_record) out_marker <= 1'b0;
        else if (emit_marker) out_marker <= 1'b1;
    end
`else
    assign counted_valid = out_valid;
`endif

    // Round-robin search starting just after the last granted lane
    always_comb begin
        grant_any  = 1'b0;
        grant_lane = last_lane;
        cand_sum   = '0;
        for (int k = 1; k <= LANES; k++) begin
            cand_sum = {1'b0, last_lane} + (LW+1)'(k);
            if (cand_sum >= (LW+1)'(LANES)) cand_sum = cand_sum - (LW+1)'(LANES);
            if (!grant_any && !empty[cand_sum[LW-1:0]]) begin
                grant_any  = 1'b1;
                grant_lane = cand_sum[LW-1:0];
            end
        end
    end

    // Once the frame quota is spoken for, granted records are popped and counted as drops
    assign fv_rise       = fv && !fv_d;
    assign can_load      = !out_valid || rdy;
    assign grant         = can_load && grant_any;
    assign pending_total = {1'b0, qv_cnt} + {16'd0, counted_valid};
    assign at_limit      = pending_total >= {1'b0, MAX_QV};
    assign load_record   = grant && !at_limit;
    assign discard       = grant && at_limit;
    assign accept        = counted_valid && rdy;

    always_comb begin
        rd = '0;
        if (grant) rd[grant_lane] = 1'b1;
    end

    always_comb begin
        drop_inc = '0;
        for (int i = 0; i < LANES; i++) begin
            if (en && dv[i] && full[i] && !rd[i]) drop_inc = drop_inc + 5'd1;
        end
        if (discard) drop_inc = drop_inc + 5'd1;
        drop_sum  = {1'b0, (fv_rise ? 16'd0 : drop_cnt)} + {12'd0, drop_inc};
        drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        qv_next   = (fv_rise ? 16'd0 : qv_cnt) + {15'd0, accept};
    end

    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            last_lane <= LW'(LANES - 1);
            fv_d      <= 1'b0;
            qv_cnt    <= '0;
            drop_cnt  <= '0;
        end else begin
            fv_d     <= fv;
            qv_cnt   <= qv_next;
            drop_cnt <= drop_next;
            if (grant) last_lane <= grant_lane;
            if (load_record) begin
                out_valid <= 1'b1;
                out_data  <= lane_dout[grant_lane];
            end
`ifdef CORNER_MERGE_EOF_EN
            else if (emit_marker) begin
                out_valid <= 1'b1;
                out_data  <= marker;
            end
`endif
            else if (rdy) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign q  = out_data;
    assign qv = out_valid;

endmodule
